// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK.
// Build option ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of running as NOPs.
module multicycle_sequencer #(
  parameter int CNT_W = 32,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic [XLEN-1:0]  instr_q,
  output logic             pc_sel,
  output logic             en_alu_n,
  output logic             en_branch_n,
  output logic             en_load_n,
  output logic             en_store_n,
  output logic             en_regfile_n,
  output logic             en_pc_n,
  output logic [CNT_W-1:0] instret,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  state_t           state_reg, state_next;
  logic [XLEN-1:0]  instr_next;
  logic             taken_reg, taken_next;
  logic [CNT_W-1:0] instret_next;
  logic             imem_req_next, dmem_req_next, dmem_we_next, pc_sel_next;
  logic             en_alu_n_next, en_branch_n_next, en_load_n_next;
  logic             en_store_n_next, en_regfile_n_next, en_pc_n_next;

  logic [6:0] op;
  logic is_legal, is_load, is_store, is_branch, is_jump, alu_used, writes_rd;

  assign op        = instr_q[6:0];
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jump   = (op == OP_JAL) || (op == OP_JALR);

  always_comb begin
    is_legal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_ALUI, OP_ALUR, OP_FENCE, OP_SYS: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  assign alu_used  = is_legal && !(op == OP_LUI || op == OP_FENCE || op == OP_SYS);
  assign writes_rd = is_legal && !(is_branch || is_store || op == OP_FENCE || op == OP_SYS);

  // Outputs are computed from the next state so they change on the same edge as the state.
  always_comb begin
    state_next   = state_reg;
    instr_next   = instr_q;
    taken_next   = taken_reg;
    instret_next = instret;
    case (state_reg)
      S_FETCH: begin
        if (imem_req && imem_ack) begin
          instr_next = imem_rdata;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        state_next = is_legal ? S_EXECUTE : S_TRAP;
`else
        state_next = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        taken_next = is_jump || (is_branch && branch_taken);
        state_next = (is_load || is_store) ? S_MEM : S_WRITEBACK;
      end
      S_MEM: begin
        if (dmem_req && dmem_ack) state_next = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        instret_next = instret + CNT_W'(1);
        state_next   = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase

    imem_req_next     = (state_next == S_FETCH);
    dmem_req_next     = (state_next == S_MEM);
    dmem_we_next      = (state_next == S_MEM) && is_store;
    en_alu_n_next     = !((state_next == S_EXECUTE) && alu_used);
    en_branch_n_next  = !((state_next == S_EXECUTE) && is_branch);
    en_load_n_next    = !((state_next == S_MEM) && is_load);
    en_store_n_next   = !((state_next == S_MEM) && is_store);
    en_regfile_n_next = !((state_next == S_WRITEBACK) && writes_rd);
    en_pc_n_next      = !(state_next == S_WRITEBACK);
    pc_sel_next       = (state_next == S_WRITEBACK) && taken_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      instr_q      <= '0;
      taken_reg    <= 1'b0;
      instret      <= '0;
      imem_req     <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      pc_sel       <= 1'b0;
      en_alu_n     <= 1'b1;
      en_branch_n  <= 1'b1;
      en_load_n    <= 1'b1;
      en_store_n   <= 1'b1;
      en_regfile_n <= 1'b1;
      en_pc_n      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      instr_q      <= instr_next;
      taken_reg    <= taken_next;
      instret      <= instret_next;
      imem_req     <= imem_req_next;
      dmem_req     <= dmem_req_next;
      dmem_we      <= dmem_we_next;
      pc_sel       <= pc_sel_next;
      en_alu_n     <= en_alu_n_next;
      en_branch_n  <= en_branch_n_next;
      en_load_n    <= en_load_n_next;
      en_store_n   <= en_store_n_next;
      en_regfile_n <= en_regfile_n_next;
      en_pc_n      <= en_pc_n_next;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap <= 1'b0;
    else        trap <= (state_next == S_TRAP);
  end
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: a phase-level model of each instruction's
// lifetime predicts every unit enable, handshake and counter value cycle by cycle.
module tb_multicycle_sequencer;

  localparam int CW = 4;
  localparam logic [10:0] RESET_V = 11'b000_1111_11_0_0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, dmem_req, dmem_we, pc_sel, trap;
  logic en_alu_n, en_branch_n, en_load_n, en_store_n, en_regfile_n, en_pc_n;
  logic [31:0] instr_q;
  logic [CW-1:0] instret;
  logic [10:0] outs;

  int tests = 0;
  int fails = 0;
  logic [CW-1:0] exp_instret = '0;

  multicycle_sequencer #(.CNT_W(CW), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .branch_taken(branch_taken), .instr_q(instr_q), .pc_sel(pc_sel),
    .en_alu_n(en_alu_n), .en_branch_n(en_branch_n), .en_load_n(en_load_n),
    .en_store_n(en_store_n), .en_regfile_n(en_regfile_n), .en_pc_n(en_pc_n),
    .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  assign outs = {imem_req, dmem_req, dmem_we, en_alu_n, en_branch_n, en_load_n,
                 en_store_n, en_regfile_n, en_pc_n, pc_sel, trap};

  function automatic logic legal(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                      7'b1110011};
  endfunction

  function automatic logic [6:0] op_of(input int idx);
    case (idx)
      0: return 7'b0110111;  1: return 7'b0010111;  2: return 7'b1101111;
      3: return 7'b1100111;  4: return 7'b1100011;  5: return 7'b0000011;
      6: return 7'b0100011;  7: return 7'b0010011;  8: return 7'b0110011;
      9: return 7'b0001111;  default: return 7'b1110011;
    endcase
  endfunction

  // Phases: 0 fetch, 1 decode, 2 execute, 3 mem, 4 writeback, 5 trap.
  function automatic logic [10:0] expv(input int ph, input logic [6:0] op, input logic tk);
    logic lg, ld, st, br, nalu, nrd;
    lg = legal(op);
    ld = (op == 7'b0000011);
    st = (op == 7'b0100011);
    br = (op == 7'b1100011);
    nalu = (op == 7'b0110111) || (op == 7'b0001111) || (op == 7'b1110011);
    nrd = br || st || (op == 7'b0001111) || (op == 7'b1110011);
    return {ph == 0, ph == 3, ph == 3 && st,
            !(ph == 2 && lg && !nalu), !(ph == 2 && br),
            !(ph == 3 && ld), !(ph == 3 && st),
            !(ph == 4 && lg && !nrd), !(ph == 4),
            ph == 4 && tk, ph == 5};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (outs !== RESET_V || instret !== '0 || instr_q !== '0) begin
      fails++;
      $display("FAIL reset_state outs=%b instret=%0d instr_q=%h want outs=%b 0 0",
               outs, instret, instr_q, RESET_V);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    exp_instret = '0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tests++;
      if (outs !== expv(0, 7'h0, 1'b0) || instret !== '0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d outs=%b instret=%0d want %b 0",
                 c, outs, instret, expv(0, 7'h0, 1'b0));
      end
      tick();
    end
  endtask

  // Expects the DUT to be one cycle into FETCH; leaves it one cycle into the next FETCH.
  task automatic run_instr(input logic [31:0] instr, input int iwait, input int dwait,
                           input logic bt, input bit abort_in_mem, input string name);
    logic [6:0] op;
    logic mem, tk;
    logic [31:0] rnd;
    op  = instr[6:0];
    mem = (op == 7'b0000011) || (op == 7'b0100011);
    tk  = (op == 7'b1101111) || (op == 7'b1100111) || (op == 7'b1100011 && bt);

    for (int w = 0; w <= iwait; w++) begin
      tests++;
      if (outs !== expv(0, op, 1'b0) || instret !== exp_instret) begin
        fails++;
        $display("FAIL %s fetch w=%0d outs=%b instret=%0d want %b %0d",
                 name, w, outs, instret, expv(0, op, 1'b0), exp_instret);
      end
      rnd = $urandom();
      imem_ack   = (w == iwait);
      imem_rdata = (w == iwait) ? instr : rnd;
      dmem_ack   = rnd[3];
      tick();
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    tests++;
    if (outs !== expv(1, op, 1'b0) || instr_q !== instr) begin
      fails++;
      $display("FAIL %s decode outs=%b instr_q=%h want %b %h",
               name, outs, instr_q, expv(1, op, 1'b0), instr);
    end
`ifdef ILLEGAL_TRAP_EN
    if (!legal(op)) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (outs !== expv(5, op, 1'b0) || instret !== exp_instret) begin
          fails++;
          $display("FAIL %s trap k=%0d outs=%b instret=%0d want %b %0d",
                   name, k, outs, instret, expv(5, op, 1'b0), exp_instret);
        end
        imem_ack = 1'b1;
        tick();
      end
      imem_ack = 1'b0;
      do_reset();
      return;
    end
`endif
    branch_taken = bt;
    tick();
    tests++;
    if (outs !== expv(2, op, 1'b0)) begin
      fails++;
      $display("FAIL %s execute outs=%b want %b", name, outs, expv(2, op, 1'b0));
    end
    tick();
    rnd = $urandom();
    branch_taken = rnd[0];

    if (mem) begin
      for (int w = 0; w <= dwait; w++) begin
        tests++;
        if (outs !== expv(3, op, 1'b0)) begin
          fails++;
          $display("FAIL %s mem w=%0d outs=%b want %b", name, w, outs, expv(3, op, 1'b0));
        end
        if (abort_in_mem) begin
          #2 rst_n = 1'b0;
          #1;
          tests++;
          if (outs !== RESET_V || instret !== '0 || instr_q !== '0) begin
            fails++;
            $display("FAIL %s async_abort outs=%b instret=%0d instr_q=%h want %b 0 0",
                     name, outs, instret, instr_q, RESET_V);
          end
          @(negedge clk);
          rst_n = 1'b1;
          exp_instret = '0;
          tick();
          tests++;
          if (outs !== expv(0, op, 1'b0) || instret !== '0) begin
            fails++;
            $display("FAIL %s restart outs=%b instret=%0d want %b 0",
                     name, outs, instret, expv(0, op, 1'b0));
          end
          return;
        end
        rnd = $urandom();
        imem_ack   = rnd[1];
        imem_rdata = rnd;
        dmem_ack   = (w == dwait);
        tick();
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
    end

    tests++;
    if (outs !== expv(4, op, tk) || instret !== exp_instret || instr_q !== instr) begin
      fails++;
      $display("FAIL %s writeback outs=%b instret=%0d instr_q=%h want %b %0d %h",
               name, outs, instret, instr_q, expv(4, op, tk), exp_instret, instr);
    end
    tick();
    exp_instret = exp_instret + 1'b1;
    tests++;
    if (outs !== expv(0, op, 1'b0) || instret !== exp_instret) begin
      fails++;
      $display("FAIL %s retire outs=%b instret=%0d want %b %0d",
               name, outs, instret, expv(0, op, 1'b0), exp_instret);
    end
  endtask

  task automatic test_directed();
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, "addi");
    run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0, "lw");
    run_instr(32'h00000463, 1, 0, 1'b1, 1'b0, "beq_taken");
    run_instr(32'h00000463, 0, 0, 1'b0, 1'b0, "beq_not_taken");
    run_instr(32'h0040006F, 2, 0, 1'b0, 1'b0, "jal");
    run_instr(32'h0020A023, 0, 2, 1'b1, 1'b0, "sw");
    run_instr(32'h0000007F, 0, 0, 1'b1, 1'b0, "illegal_7f");
  endtask

  task automatic test_reset_mid_mem();
    run_instr(32'h0020A023, 1, 2, 1'b0, 1'b1, "sw_abort");
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, "addi_after_abort");
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [6:0] op;
    int idx;
    for (int n = 0; n < 250; n++) begin
      r = $urandom();
      idx = $urandom_range(0, 12);
      if (idx < 11) begin
        op = op_of(idx);
      end else begin
        op = 7'b1111111;
        for (int t = 0; t < 64 && legal(op); t++) op = 7'($urandom_range(0, 127));
        if (legal(op)) op = 7'b1111111;
      end
      run_instr({r[31:7], op}, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_mem();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the RV32I core. It fetches one instruction at a time over a req/ack instruction-memory handshake and decodes the 7-bit opcode. It then steps the datapath through EXECUTE, optional MEM and WRITEBACK, driving the same active-low unit enables (0 = enabled, 1 = disabled) that the datapath units consume. One instruction is in flight at a time; there is no pipelining.

Parameters:
CNT_W, 32, width of retired-instruction counter instret
XLEN, 32, instruction width captured from imem_rdata

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  XLEN  fetched instruction
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
dmem_ack  in  1  data access complete
branch_taken  in  1  branch unit result, sampled in EXECUTE
instr_q  out  XLEN  latched current instruction
pc_sel  out  1  0 = PC+4, 1 = computed target; valid while en_pc_n=0
en_alu_n, en_branch_n, en_load_n, en_store_n, en_regfile_n, en_pc_n  out  1 each  active-low unit enables
instret  out  CNT_W  retired-instruction count
trap  out  1  illegal-opcode trap, sticky (ILLEGAL_TRAP_EN only)

Behaviour:
- Reset (async, rst_n=0): state=FETCH; instr_q=0, instret=0, pc_sel=0, trap=0, imem_req=0, dmem_req=0, dmem_we=0; all en_*_n=1. imem_req rises on the first clock after rst_n deasserts.
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, ALU_IMM 0010011, ALU_REG 0110011, FENCE 0001111, SYS 1110011. Any other value is illegal.
- FETCH: imem_req=1 and held until imem_ack. On the ack edge, instr_q<=imem_rdata, imem_req drops, next state is DECODE. A zero-wait ack (ack in the first req cycle) is legal.
- DECODE: one cycle, all enables=1. Next state is EXECUTE. Illegal opcodes are handled per Optional Feature.
- EXECUTE: one cycle. en_alu_n=0 for every opcode except LUI, FENCE and SYS. en_branch_n=0 for BRANCH only. A taken flag is latched: taken = JAL | JALR | (BRANCH & branch_taken). Next state is MEM for LOAD/STORE, otherwise WRITEBACK.
- MEM: dmem_req=1 and dmem_we=(opcode==STORE), held stable until dmem_ack. en_load_n=0 (LOAD) or en_store_n=0 (STORE) for the whole state. On the ack edge, next state is WRITEBACK.
- WRITEBACK: one cycle.
  - en_regfile_n=0 unless the opcode is BRANCH, STORE, FENCE, SYS or illegal.
  - en_pc_n=0 always; pc_sel=taken.
  - instret increments by 1, wrapping at 2^CNT_W-1 to 0.
  - Next state is FETCH.
- Latency with zero-wait memories: non-memory instructions take 4 cycles (F, D, E, W); LOAD/STORE take 5.
- An ack arriving while its req=0 is ignored with no state change. imem_ack and dmem_ack together: only the ack of the active state is honoured.
- Reset mid-operation: all state aborts, outputs return to reset values immediately, and the in-flight access is dropped without retry.
- Enables and req outputs are registered with the state, decoded from state + instr_q, and glitch-free.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE moves to TRAP. TRAP sets trap=1, holds all enables=1 and imem_req=0, does not increment instret, and remains until rst_n=0.
- Undefined: the trap port is tied to 0. An illegal opcode runs as a NOP (D→E→W with ALU disabled, en_pc_n=0, pc_sel=0, instret increments).

Test Plan:
- Reset release, imem_ack held 0 → imem_req=1 from cycle 1, all en_*_n=1, instret=0, stays in FETCH indefinitely.
- ADDI 0x00500093, ack in first req cycle → en_alu_n=0 one cycle later; WRITEBACK shows en_regfile_n=0, en_pc_n=0, pc_sel=0; instret=1; 4 cycles total.
- LW 0x0000A103, dmem_ack after 3 wait cycles → dmem_req=1, dmem_we=0, en_load_n=0 for 4 cycles, then regfile write; 8 cycles total.
- BEQ 0x00000463 with branch_taken=1 → en_branch_n=0 in EXECUTE; WRITEBACK: en_regfile_n=1, pc_sel=1. Repeat with branch_taken=0 → pc_sel=0.
- rst_n pulsed low during MEM of SW 0x0020A023 → dmem_req drops asynchronously, then restarts in FETCH with instret=0.
- Opcode 0x0000007F: with ILLEGAL_TRAP_EN → trap=1 after DECODE, no further imem_req, instret unchanged; without it → treated as NOP, instret increments.
